alu_step_ctrl: RTL and testbench

Sequential operand-entry and execute controller for the 16-bit ALU board demo. It replaces direct switch-to-ALU wiring with a debounced, key-stepped state machine: capture operand A, capture operand B, execute, then hold the result. Operands and opcode are registered and driven to an external `alu16`; its result and flags are registered back for the HEX/LEDR outputs. Width, debounce length and ALU latency are parameters.

---
 rtl/alu_step_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alu_step_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_step_ctrl
// Brief    : Debounced key-stepped operand entry / execute / show controller
//            driving an external alu16. Optional macro: ALU_ACCUM_EN
//            (SHOW + step chains the result into operand A).
// Revision : 1.0 - initial release
// ============================================================================
module alu_step_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ALU_LAT         = 0
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic [9:0]       SW,
    input  logic [1:0]       KEY,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [4:0]       alu_flags,
    output logic [WIDTH-1:0] disp_val,
    output logic [4:0]       flags_q,
    output logic [1:0]       state_q,
    output logic             done
);

    localparam int         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    localparam logic [1:0] S_ENTER_A = 2'd0;
    localparam logic [1:0] S_ENTER_B = 2'd1;
    localparam logic [1:0] S_EXEC    = 2'd2;
    localparam logic [1:0] S_SHOW    = 2'd3;

    if (WIDTH < 8) begin : g_chk_width
        $error("alu_step_ctrl: WIDTH must be >= 8");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("alu_step_ctrl: DEBOUNCE_CYCLES must be >= 2");
    end
    if (ALU_LAT < 0 || ALU_LAT > 7) begin : g_chk_lat
        $error("alu_step_ctrl: ALU_LAT must be 0..7");
    end

    logic [1:0] key_press;

    // Sync -> debounce -> falling-edge pulse; the pulse lags the debounced level by one cycle.
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        logic             level_q;
        logic             level_dly_q;
        logic             press_q;
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q     <= 1'b1;
                sync2_q     <= 1'b1;
                level_q     <= 1'b1;
                level_dly_q <= 1'b1;
                press_q     <= 1'b0;
                cnt_q       <= '0;
            end else begin
                sync1_q     <= KEY[k];
                sync2_q     <= sync1_q;
                level_dly_q <= level_q;
                press_q     <= level_dly_q & ~level_q;
                if (sync2_q != level_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level_q <= sync2_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign key_press[k] = press_q;
    end

    logic             step_press;
    logic             clr_press;
    logic [WIDTH-1:0] entry_val;
    logic [4:0]       op_map;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [4:0]       alu_op_q;
    logic [2:0]       wait_q;
    logic [1:0]       state_d;

    assign step_press = key_press[0];
    assign clr_press  = key_press[1];
    assign entry_val  = {{(WIDTH-7){SW[6]}}, SW[6:0]};

    always_comb begin
        case (SW[9:7])
            3'd0:    op_map = 5'd0;
            3'd1:    op_map = 5'd8;
            3'd2:    op_map = 5'd14;
            3'd3:    op_map = 5'd16;
            3'd4:    op_map = 5'd18;
            3'd5:    op_map = 5'd20;
            3'd6:    op_map = 5'd21;
            default: op_map = 5'd23;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = S_ENTER_A;
        end else begin
            case (state_q)
                S_ENTER_A: if (step_press) state_d = S_ENTER_B;
                S_ENTER_B: if (step_press) state_d = S_EXEC;
                S_EXEC:    if (wait_q == 3'd0) state_d = S_SHOW;
                default: begin
`ifdef ALU_ACCUM_EN
                    if (step_press) state_d = S_ENTER_B;
`else
                    if (step_press) state_d = S_ENTER_A;
`endif
                end
            endcase
        end
    end

    always_comb begin
        done     = (state_q == S_SHOW);
        disp_val = (state_q == S_SHOW) ? res_q : entry_val;
    end

    // Clear outranks step; in EXEC only the wait counter matters.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            wait_q   <= '0;
        end else if (clr_press) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (step_press) alu_a_q <= entry_val;
                end
                S_ENTER_B: begin
                    if (step_press) begin
                        alu_b_q  <= entry_val;
                        alu_op_q <= op_map;
                        wait_q   <= LAT_INIT;
                    end
                end
                S_EXEC: begin
                    if (wait_q == 3'd0) begin
                        flags_q <= alu_flags;
                        res_q   <= alu_y;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                default: begin
`ifdef ALU_ACCUM_EN
                    if (step_press) alu_a_q <= res_q;
`endif
                end
            endcase
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_step_ctrl
// Brief    : Scoreboard bench for alu_step_ctrl with a behavioural alu16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_step_ctrl;

    localparam int W   = 16;
    localparam int DB  = 4;
    localparam int LAT = 0;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [9:0]   SW    = '0;
    logic [1:0]   KEY   = 2'b11;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [4:0]   alu_op;
    logic [W-1:0] alu_y;
    logic [4:0]   alu_flags;
    logic [W-1:0] disp_val;
    logic [4:0]   flags_q;
    logic [1:0]   state_q;
    logic         done;

    alu_step_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .ALU_LAT(LAT)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .SW       (SW),
        .KEY      (KEY),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_y    (alu_y),
        .alu_flags(alu_flags),
        .disp_val (disp_val),
        .flags_q  (flags_q),
        .state_q  (state_q),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Behavioural alu16: returns {C,F,Z,L,N, y}.
    function automatic logic [W+4:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [4:0] op);
        logic [W:0]   r;
        logic [W-1:0] y;
        logic         f;
        r = '0;
        f = 1'b0;
        case (op)
            5'd0: begin
                r = {1'b0, a} + {1'b0, b};
                f = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            5'd8: begin
                r = {1'b0, a} - {1'b0, b};
                f = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            5'd14:   r = {1'b0, a & b};
            5'd16:   r = {1'b0, a | b};
            5'd18:   r = {1'b0, a ^ b};
            5'd20:   r = {1'b0, ~a};
            5'd21:   r = {a, 1'b0};
            5'd23:   r = {2'b00, a[W-1:1]};
            default: r = '0;
        endcase
        y = r[W-1:0];
        return {r[W], f, (y == '0), ($signed(a) < $signed(b)), y[W-1], y};
    endfunction

    assign {alu_flags, alu_y} = alu_model(alu_a, alu_b, alu_op);

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    int step_pulses    = 0;
    int last_pulse_cyc = 0;
    always @(negedge clk) begin
        if (dut.key_press[0]) begin
            step_pulses    <= step_pulses + 1;
            last_pulse_cyc <= cyc;
        end
    end

    typedef struct {
        logic [W-1:0] v;
        logic         n;
    } exp_t;
    exp_t sb_q[$];

    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            chk("sb_pending", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_disp", disp_val, e.v);
                chk("sb_nflag", flags_q[0], e.n);
            end
        end
        done_prev <= done;
    end

    task automatic press_keys(input logic [1:0] mask);
        KEY = ~mask;
        repeat (DB + 8) @(negedge clk);
        KEY = 2'b11;
        repeat (DB + 8) @(negedge clk);
    endtask

    task automatic push_exp(input logic [W-1:0] v, input logic n);
        exp_t e;
        e.v = v;
        e.n = n;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        int t0;
        logic found;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_alu_b", alu_b, 16'h0000);
        chk("rst_alu_op", alu_op, 5'd0);
        chk("rst_flags", flags_q, 5'd0);
        chk("rst_state", state_q, 2'd0);
        chk("rst_done", done, 1'b0);

        // ADD 5 + 16
        SW = 10'h005;
        @(negedge clk);
        chk("disp_live", disp_val, 16'h0005);
        press_keys(2'b01);
        chk("add_state_b", state_q, 2'd1);
        chk("add_alu_a", alu_a, 16'h0005);
        SW = 10'h010;
        push_exp(16'h0015, 1'b0);
        press_keys(2'b01);
        chk("add_alu_b", alu_b, 16'h0010);
        chk("add_alu_op", alu_op, 5'd0);
        chk("add_state_show", state_q, 2'd3);
        chk("add_done", done, 1'b1);
        chk("add_disp", disp_val, 16'h0015);
        press_keys(2'b01);
`ifdef ALU_ACCUM_EN
        chk("show_step_state", state_q, 2'd1);
        chk("show_step_alu_a", alu_a, 16'h0015);
        press_keys(2'b10);
        chk("clr_state", state_q, 2'd0);
`else
        chk("show_step_state", state_q, 2'd0);
        chk("show_step_alu_a", alu_a, 16'h0005);
`endif

        // SUB -1 - 1
        SW = 10'h07F;
        press_keys(2'b01);
        chk("sub_alu_a", alu_a, 16'hFFFF);
        SW = 10'h081;
        push_exp(16'hFFFE, 1'b1);
        press_keys(2'b01);
        chk("sub_alu_op", alu_op, 5'd8);
        chk("sub_disp", disp_val, 16'hFFFE);
        chk("sub_nflag", flags_q[0], 1'b1);
        press_keys(2'b10);
        chk("sub_clr_state", state_q, 2'd0);
        chk("sub_clr_flags", flags_q, 5'd0);

        // Bounce: low 3, high 1, low 5+
        SW = 10'h003;
        p0 = step_pulses;
        KEY[0] = 1'b0;
        repeat (3) @(negedge clk);
        KEY[0] = 1'b1;
        @(negedge clk);
        KEY[0] = 1'b0;
        t0 = cyc;
        repeat (DB + 8) @(negedge clk);
        KEY[0] = 1'b1;
        repeat (DB + 8) @(negedge clk);
        chk("bounce_pulses", step_pulses - p0, 1);
        chk("bounce_delay", last_pulse_cyc - t0, 7);
        chk("bounce_state", state_q, 2'd1);
        chk("bounce_alu_a", alu_a, 16'h0003);

        // Step and clear together in ENTER_B
        SW = 10'h0A5;
        press_keys(2'b11);
        chk("prio_state", state_q, 2'd0);
        chk("prio_alu_a", alu_a, 16'h0000);
        chk("prio_alu_b", alu_b, 16'h0000);
        chk("prio_alu_op", alu_op, 5'd0);

        // 3 + 4, then step from SHOW
        SW = 10'h003;
        press_keys(2'b01);
        SW = 10'h004;
        push_exp(16'h0007, 1'b0);
        press_keys(2'b01);
        chk("chain_show", state_q, 2'd3);
        press_keys(2'b01);
`ifdef ALU_ACCUM_EN
        chk("accum_state", state_q, 2'd1);
        chk("accum_alu_a", alu_a, 16'h0007);
        SW = 10'h002;
        push_exp(16'h0009, 1'b0);
        press_keys(2'b01);
        chk("accum_disp", disp_val, 16'h0009);
`else
        chk("chain_state", state_q, 2'd0);
        chk("chain_alu_a", alu_a, 16'h0003);
`endif
        press_keys(2'b10);
        chk("chain_clr_state", state_q, 2'd0);

        // Reset while in EXEC
        SW = 10'h011;
        press_keys(2'b01);
        SW = 10'h022;
        KEY[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state_q == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("exec_reached", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state_q, 2'd0);
        chk("mid_rst_alu_a", alu_a, 16'h0000);
        chk("mid_rst_alu_b", alu_b, 16'h0000);
        chk("mid_rst_alu_op", alu_op, 5'd0);
        chk("mid_rst_flags", flags_q, 5'd0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_disp", disp_val, 16'h0022);
        repeat (3) @(negedge clk);
        KEY = 2'b11;
        repeat (3) @(negedge clk);
        p0 = step_pulses;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_pulses", step_pulses - p0, 0);
        chk("post_rst_state", state_q, 2'd0);

        chk("sb_leftover", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
